vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator; successor to the fixed 640x480 controller.
- Runs entirely in the system clock domain. Pixel rate comes from a programmable clock-enable strobe, not a divided clock.
- Adds: arbitrary mode geometry, per-axis sync polarity, run/pause enable, line/frame start strobes, frame counter, and a configurable sync/blank delay line that matches downstream pixel-pipeline latency.
- Feeds x/y to the frame-buffer/sprite pipeline and sync/blank to the DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- PIPE_DLY, 0, extra pixel ticks of delay on hsync/vsync/blank_b (0..7)
- CW, 10, x/y counter width
- FRAME_W, 16, frame counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low pauses timing
- pix_en  out  1  one-clk pixel-tick strobe
- x  out  CW  current horizontal count
- y  out  CW  current vertical count
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- blank_b  out  1  high in visible region
- line_start  out  1  one-clk pulse at start of each line
- frame_start  out  1  one-clk pulse at start of each frame
- frame_cnt  out  FRAME_W  completed-frame count

Behaviour:
- HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration: fatal error if HTOTAL-1 or VTOTAL-1 does not fit CW, if CLK_DIV<1, or if PIPE_DLY>7.
- Reset (asynchronous, takes effect immediately): div_cnt=0, x=0, y=0, frame_cnt=0, pix_en=0. Every delay-line stage holds the inactive levels: hsync=~H_POL, vsync=~V_POL, blank_b=0. line_start=0, frame_start=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - pix_en = en & (div_cnt==CLK_DIV-1), combinational from registered state.
  - CLK_DIV=1 gives pix_en=en.
- Counters update only on the clk edge where pix_en=1:
  - x increments; at x==HTOTAL-1, x wraps to 0 and y increments.
  - At x==HTOTAL-1 and y==VTOTAL-1, y wraps to 0 and frame_cnt increments, wrapping modulo 2^FRAME_W.
- Raw timing, decoded from the current x/y:
  - hs_act = (x >= H_ACTIVE+H_FP) & (x < H_ACTIVE+H_FP+H_SYNC)
  - vs_act = same form on y using the V parameters
  - vis = (x < H_ACTIVE) & (y < V_ACTIVE)
- Output pipeline:
  - Stage 0 registers {hs_act?H_POL:~H_POL, vs_act?V_POL:~V_POL, vis} on pix_en.
  - Then PIPE_DLY further stages, each shifting on pix_en only.
  - hsync/vsync/blank_b show the decode of coordinate (x,y) exactly 1+PIPE_DLY pixel ticks after that coordinate appeared on x/y.
- Strobes (combinational, registered state only, one clk wide):
  - line_start = pix_en & (x==0)
  - frame_start = pix_en & (x==0) & (y==0)
  - The first frame_start after reset is on the first pix_en.
- en=0:
  - div_cnt, x, y, frame_cnt and the delay line all hold.
  - pix_en, line_start and frame_start are 0.
  - Outputs keep their last values.
  - Re-asserting en resumes from the held div_cnt; no tick is lost or duplicated.
- Mid-operation reset: all state returns to reset values without a clock edge. After reset_n deasserts, operation restarts at x=y=0.

Test Plan:
- Defaults, en=1 -> pix_en every 2nd clk; x runs 0..799 then 0; y increments on the x 799->0 tick; y runs 0..524; frame_cnt=1 after 420000 pix ticks; frame_start once per 840000 clks.
- Defaults, one frame -> hsync low exactly 96 ticks per line, falling 1 tick after x=656; vsync low for lines 490-491 only; blank_b high for exactly 307200 ticks per frame.
- PIPE_DLY=3 -> hsync falls 4 pix ticks after x==656 is presented; blank_b falls 4 ticks after x==640.
- H_POL=V_POL=1, H=4/1/2/1, V=3/1/1/1, CLK_DIV=1 -> HTOTAL=8; hsync high for decoded x=5,6; vsync high for y=4; frame every 48 clks; with FRAME_W=2, frame_cnt wraps 3->0.
- en low for 10 clks at x=300 -> x holds 300, pix_en and strobes 0; after en returns high, next tick gives x=301 with no skipped or repeated value.
- reset_n pulsed low between clk edges mid-frame -> x=y=frame_cnt=0, hsync=1, vsync=1, blank_b=0 immediately; after release, frame_start pulses on the first pix_en.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-tick divider, x/y/frame counters,
// sync/blank decode and a pixel-tick delay line for pipeline latency matching.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int PIPE_DLY = 0,
   parameter int CW       = 10,
   parameter int FRAME_W  = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   output logic               pix_en,
   output logic [CW-1:0]      x,
   output logic [CW-1:0]      y,
   output logic               hsync,
   output logic               vsync,
   output logic               blank_b,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HS_B   = H_ACTIVE + H_FP;
   localparam int HS_E   = HS_B + H_SYNC;
   localparam int VS_B   = V_ACTIVE + V_FP;
   localparam int VS_E   = VS_B + V_SYNC;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(HTOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(VTOTAL - 1);
   localparam logic [2:0]    IDLE     = {~H_POL, ~V_POL, 1'b0};

   if ((64'(HTOTAL - 1) >= (64'd1 << CW)) ||
       (64'(VTOTAL - 1) >= (64'd1 << CW))) begin : g_bad_cw
      $fatal(1, "vga_timing_gen: HTOTAL/VTOTAL do not fit CW");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $fatal(1, "vga_timing_gen: CLK_DIV must be >= 1");
   end
   if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
      $fatal(1, "vga_timing_gen: PIPE_DLY must be 0..7");
   end

   logic [DW-1:0]      div_q, div_d;
   logic [CW-1:0]      x_q, x_d;
   logic [CW-1:0]      y_q, y_d;
   logic [FRAME_W-1:0] frm_q, frm_d;
   logic [2:0]         pipe_q [PIPE_DLY+1];
   logic               tick;
   logic               hs_act;
   logic               vs_act;
   logic               vis;
   logic [2:0]         raw;

   // reset_n gating keeps pix_en low during reset even when CLK_DIV=1
   assign tick = en & reset_n & (div_q == DIV_LAST);

   always_comb begin
      div_d = div_q;
      x_d   = x_q;
      y_d   = y_q;
      frm_d = frm_q;
      if (en) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
      if (tick) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
               y_d   = '0;
               frm_d = frm_q + FRAME_W'(1);
            end else begin
               y_d = y_q + CW'(1);
            end
         end else begin
            x_d = x_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         frm_q <= '0;
      end else begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
         frm_q <= frm_d;
      end
   end

   assign hs_act = (32'(x_q) >= 32'(HS_B)) && (32'(x_q) < 32'(HS_E));
   assign vs_act = (32'(y_q) >= 32'(VS_B)) && (32'(y_q) < 32'(VS_E));
   assign vis    = (32'(x_q) < 32'(H_ACTIVE)) && (32'(y_q) < 32'(V_ACTIVE));
   assign raw    = {hs_act ? H_POL : ~H_POL, vs_act ? V_POL : ~V_POL, vis};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= PIPE_DLY; i++) pipe_q[i] <= IDLE;
      end else if (tick) begin
         pipe_q[0] <= raw;
         for (int i = 1; i <= PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign pix_en      = tick;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_cnt   = frm_q;
   assign hsync       = pipe_q[PIPE_DLY][2];
   assign vsync       = pipe_q[PIPE_DLY][1];
   assign blank_b     = pipe_q[PIPE_DLY][0];
   assign line_start  = tick & (x_q == '0);
   assign frame_start = tick & (x_q == '0) & (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries checked every cycle against a
// tick-count model, plus hand-computed literal expectations.
module tb_vga_timing_gen;

   localparam int N = 3;
   localparam int P_HA [N]  = '{640, 8, 4};
   localparam int P_HF [N]  = '{16, 2, 1};
   localparam int P_HS [N]  = '{96, 3, 2};
   localparam int P_HB [N]  = '{48, 2, 1};
   localparam int P_VA [N]  = '{480, 4, 3};
   localparam int P_VF [N]  = '{10, 1, 1};
   localparam int P_VS [N]  = '{2, 2, 1};
   localparam int P_VB [N]  = '{33, 1, 1};
   localparam bit P_HP [N]  = '{1'b0, 1'b0, 1'b1};
   localparam bit P_VP [N]  = '{1'b0, 1'b0, 1'b1};
   localparam int P_DIV [N] = '{2, 3, 1};
   localparam int P_DLY [N] = '{0, 3, 0};
   localparam int P_CW [N]  = '{10, 5, 4};
   localparam int P_FW [N]  = '{16, 4, 2};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic en = 1'b0;
   bit   done = 1'b0;
   bit   hit300 = 1'b0;

   logic [N-1:0] pe_a, hs_a, vs_a, bb_a, ls_a, fs_a;
   logic [31:0]  x_a [N];
   logic [31:0]  y_a [N];
   logic [31:0]  f_a [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int CWG = P_CW[g];
      localparam int FWG = P_FW[g];
      logic [CWG-1:0] xw, yw;
      logic [FWG-1:0] fw;
      logic pe, hs, vs, bb, ls, fs;
      vga_timing_gen #(
         .H_ACTIVE(P_HA[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]),
         .V_ACTIVE(P_VA[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]), .V_BP(P_VB[g]),
         .H_POL(P_HP[g]), .V_POL(P_VP[g]), .CLK_DIV(P_DIV[g]),
         .PIPE_DLY(P_DLY[g]), .CW(CWG), .FRAME_W(FWG)
      ) u_dut (
         .clk(clk), .reset_n(reset_n), .en(en), .pix_en(pe),
         .x(xw), .y(yw), .hsync(hs), .vsync(vs), .blank_b(bb),
         .line_start(ls), .frame_start(fs), .frame_cnt(fw)
      );
      assign pe_a[g] = pe;
      assign hs_a[g] = hs;
      assign vs_a[g] = vs;
      assign bb_a[g] = bb;
      assign ls_a[g] = ls;
      assign fs_a[g] = fs;
      assign x_a[g]  = 32'(xw);
      assign y_a[g]  = 32'(yw);
      assign f_a[g]  = 32'(fw);
   end

   function automatic longint ht(int g);
      return longint'(P_HA[g] + P_HF[g] + P_HS[g] + P_HB[g]);
   endfunction

   function automatic longint vt(int g);
      return longint'(P_VA[g] + P_VF[g] + P_VS[g] + P_VB[g]);
   endfunction

   // {hsync, vsync, blank_b} for the k-th coordinate since restart
   function automatic logic [2:0] dec(int g, longint k);
      longint hx, vy;
      logic hs, vs, vis;
      if (k < 0) return {~P_HP[g], ~P_VP[g], 1'b0};
      hx  = k % ht(g);
      vy  = (k / ht(g)) % vt(g);
      hs  = (hx >= P_HA[g] + P_HF[g]) && (hx < P_HA[g] + P_HF[g] + P_HS[g]);
      vs  = (vy >= P_VA[g] + P_VF[g]) && (vy < P_VA[g] + P_VF[g] + P_VS[g]);
      vis = (hx < P_HA[g]) && (vy < P_VA[g]);
      return {hs ? P_HP[g] : ~P_HP[g], vs ? P_VP[g] : ~P_VP[g], vis};
   endfunction

   task automatic chk(input string nm, input int g, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, g, act, exp,
                  $time);
      end
   endtask

   longint t [N];
   int     d [N];

   initial begin
      longint ex, ey, ef;
      logic   epe;
      logic [2:0] o;
      for (int g = 0; g < N; g++) begin
         t[g] = 0;
         d[g] = 0;
      end
      forever begin
         @(posedge clk);
         if (reset_n && en) begin
            for (int g = 0; g < N; g++) begin
               if (d[g] == P_DIV[g] - 1) begin
                  t[g] = t[g] + 1;
                  d[g] = 0;
               end else begin
                  d[g] = d[g] + 1;
               end
            end
         end
         @(negedge clk);
         if (done) break;
         if (!reset_n) begin
            for (int g = 0; g < N; g++) begin
               t[g] = 0;
               d[g] = 0;
            end
         end
         for (int g = 0; g < N; g++) begin
            ex  = t[g] % ht(g);
            ey  = (t[g] / ht(g)) % vt(g);
            ef  = (t[g] / (ht(g) * vt(g))) % (longint'(1) << P_FW[g]);
            epe = en & reset_n & (d[g] == P_DIV[g] - 1);
            o   = dec(g, t[g] - 1 - P_DLY[g]);
            chk("pix_en", g, pe_a[g], epe);
            chk("x", g, x_a[g], ex);
            chk("y", g, y_a[g], ey);
            chk("frame_cnt", g, f_a[g], ef);
            chk("hsync", g, hs_a[g], o[2]);
            chk("vsync", g, vs_a[g], o[1]);
            chk("blank_b", g, bb_a[g], o[0]);
            chk("line_start", g, ls_a[g], epe & (ex == 0));
            chk("frame_start", g, fs_a[g], epe & (ex == 0) & (ey == 0));
         end
         if (y_a[0] == 0 && x_a[0] == 657) chk("lit_hs_low_656", 0, hs_a[0], 0);
         if (y_a[0] == 0 && x_a[0] == 656) chk("lit_hs_high_655", 0, hs_a[0], 1);
         if (y_a[0] == 0 && x_a[0] == 641) chk("lit_blank_640", 0, bb_a[0], 0);
         if (y_a[0] == 0 && x_a[0] == 640) chk("lit_blank_639", 0, bb_a[0], 1);
         if (y_a[1] == 0 && x_a[1] == 14) chk("lit_dly_hs_on", 1, hs_a[1], 0);
         if (y_a[1] == 0 && x_a[1] == 13) chk("lit_dly_hs_off", 1, hs_a[1], 1);
         if (y_a[1] == 0 && x_a[1] == 12) chk("lit_dly_bb_off", 1, bb_a[1], 0);
         if (y_a[1] == 0 && x_a[1] == 11) chk("lit_dly_bb_on", 1, bb_a[1], 1);
         if (x_a[2] == 6) chk("lit_pos_hs_5", 2, hs_a[2], 1);
         if (x_a[2] == 7) chk("lit_pos_hs_6", 2, hs_a[2], 1);
         if (x_a[2] == 0 && y_a[2] == 1) chk("lit_pos_hs_7", 2, hs_a[2], 0);
         if (y_a[2] == 4 && x_a[2] == 1) chk("lit_pos_vs_4", 2, vs_a[2], 1);
         if (y_a[2] == 4 && x_a[2] == 0) chk("lit_pos_vs_3", 2, vs_a[2], 0);
         if (t[2] == 191) chk("lit_frm_3", 2, f_a[2], 3);
         if (t[2] == 192) chk("lit_frm_wrap", 2, f_a[2], 0);
      end
      chk("reach_x300", 0, hit300, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #8 reset_n = 1'b1;
      @(posedge clk);
      #1 en = 1'b1;
      for (int i = 0; i < 3000 && !hit300; i++) begin
         @(posedge clk);
         #1;
         if (x_a[0] == 300) hit300 = 1'b1;
      end
      en = 1'b0;
      repeat (10) @(posedge clk);
      #1 en = 1'b1;
      repeat (1500) @(posedge clk);
      #2 reset_n = 1'b0;
      #6 reset_n = 1'b1;
      repeat (400) @(posedge clk);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1 en = ($urandom_range(3) != 0);
      end
      @(posedge clk);
      #1 en = 1'b1;
      repeat (50) @(posedge clk);
      #1 done = 1'b1;
   end

endmodule
